fb_wr_sched: RTL and testbench

Framebuffer write-port scheduler for the vdp. It shares the single framebuffer write port (fb_wclk, fb_wadr, fb_we, fb_d) between two pixel-write clients and a built-in rectangle-free linear fill engine, which is used for screen clear and span fills. It sits between the pixel producers and the framebuffer RAM that the vdp scan-out reads from.

---
 rtl/fb_wr_sched.sv | 119 +++++++++++
 tb/tb_fb_wr_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_wr_sched.sv
// Framebuffer write-port scheduler: round-robin arbitration between two pixel
// clients plus a linear fill engine, all sharing one registered write port.
module fb_wr_sched #(
  parameter int AW       = 16,
  parameter int DW       = 24,
  parameter int FB_WORDS = 64000
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          c0_valid,
  output logic          c0_ready,
  input  logic [AW-1:0] c0_adr,
  input  logic [DW-1:0] c0_d,
  input  logic          c1_valid,
  output logic          c1_ready,
  input  logic [AW-1:0] c1_adr,
  input  logic [DW-1:0] c1_d,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_first,
  input  logic [AW-1:0] fill_last,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          oob,
  output logic          fb_wclk,
  output logic          fb_we,
  output logic [AW-1:0] fb_wadr,
  output logic [DW-1:0] fb_d
);

  localparam logic [0:0]    ST_ARB     = 1'b0;
  localparam logic [0:0]    ST_FILL    = 1'b1;
  localparam logic [AW-1:0] LAST_VALID = AW'(FB_WORDS - 1);

  logic [0:0]    r_state;
  logic          r_last;      // 1 = c1 was granted most recently
  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_fill_last;
  logic [DW-1:0] r_color;
  logic          r_we;
  logic [AW-1:0] r_wadr;
  logic [DW-1:0] r_d;
  logic          r_done;
  logic          r_oob;

  logic          w_arb;
  logic          w_g0;
  logic          w_g1;
  logic [AW-1:0] w_clamp_last;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;

  // Grants are combinational; gating with rst_n keeps both readys low in reset.
  assign w_arb        = rst_n && (r_state == ST_ARB) && !fill_start;
  assign w_g0         = w_arb && c0_valid && (!c1_valid || r_last);
  assign w_g1         = w_arb && c1_valid && (!c0_valid || !r_last);
  assign w_clamp_last = (fill_last > LAST_VALID) ? LAST_VALID : fill_last;
  assign w_adr        = w_g1 ? c1_adr : c0_adr;
  assign w_dat        = w_g1 ? c1_d   : c0_d;

  assign c0_ready  = w_g0;
  assign c1_ready  = w_g1;
  assign fill_busy = (r_state == ST_FILL);
  assign fill_done = r_done;
  assign oob       = r_oob;
  assign fb_wclk   = CLOCK_50;
  assign fb_we     = r_we;
  assign fb_wadr   = r_wadr;
  assign fb_d      = r_d;

  // NOTE: every state register uses <= so all flops sample pre-edge values together.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARB;
      r_last      <= 1'b1;
      r_cur       <= '0;
      r_fill_last <= '0;
      r_color     <= '0;
      r_we        <= 1'b0;
      r_wadr      <= '0;
      r_d         <= '0;
      r_done      <= 1'b0;
      r_oob       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_oob  <= 1'b0;
      if (r_state == ST_FILL) begin
        r_we   <= 1'b1;
        r_wadr <= r_cur;
        r_d    <= r_color;
        r_cur  <= r_cur + 1'b1;
        if (r_cur == r_fill_last) begin
          r_state <= ST_ARB;
          r_done  <= 1'b1;
        end
      end else if (fill_start) begin
        r_cur       <= fill_first;
        r_fill_last <= w_clamp_last;
        r_color     <= fill_color;
        if (fill_first <= w_clamp_last) begin
          r_state <= ST_FILL;
        end else begin
          r_done <= 1'b1;
        end
      end else if (w_g0 || w_g1) begin
        r_last <= w_g1;
        if (w_adr <= LAST_VALID) begin
          r_we   <= 1'b1;
          r_wadr <= w_adr;
          r_d    <= w_dat;
        end else begin
          r_oob <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_wr_sched.sv
// Scoreboard bench for fb_wr_sched: expected framebuffer writes are queued as
// stimulus is driven and popped by a monitor whenever fb_we is observed.
module tb_fb_wr_sched;

  localparam int AW = 16;
  localparam int DW = 24;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] d;
  } wr_t;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          c0_valid = 1'b0, c1_valid = 1'b0;
  logic          c0_ready, c1_ready;
  logic [AW-1:0] c0_adr = '0, c1_adr = '0;
  logic [DW-1:0] c0_d = '0, c1_d = '0;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_first = '0, fill_last = '0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy, fill_done, oob;
  logic          fb_wclk, fb_we;
  logic [AW-1:0] fb_wadr;
  logic [DW-1:0] fb_d;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  fb_wr_sched dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .c0_valid  (c0_valid),
    .c0_ready  (c0_ready),
    .c0_adr    (c0_adr),
    .c0_d      (c0_d),
    .c1_valid  (c1_valid),
    .c1_ready  (c1_ready),
    .c1_adr    (c1_adr),
    .c1_d      (c1_d),
    .fill_start(fill_start),
    .fill_first(fill_first),
    .fill_last (fill_last),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .oob       (oob),
    .fb_wclk   (fb_wclk),
    .fb_we     (fb_we),
    .fb_wadr   (fb_wadr),
    .fb_d      (fb_d)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] adr, input logic [DW-1:0] d);
    wr_t w;
    w.adr = adr;
    w.d   = d;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    @(negedge CLOCK_50);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_we"},    fb_we,     0);
    check({tag, "_wadr"},  fb_wadr,   0);
    check({tag, "_d"},     fb_d,      0);
    check({tag, "_busy"},  fill_busy, 0);
    check({tag, "_done"},  fill_done, 0);
    check({tag, "_oob"},   oob,       0);
    check({tag, "_rdy0"},  c0_ready,  0);
    check({tag, "_rdy1"},  c1_ready,  0);
  endtask

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr_adr", {16'h0, fb_wadr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_adr", fb_wadr, w.adr);
        check("wr_d",   fb_d,    w.d);
      end
    end
  end

  initial begin
    logic [AW-1:0] a0, a1;
    int g;

    // Reset state, with a client already requesting.
    c0_valid = 1'b1;
    c0_adr   = 16'h0001;
    @(negedge CLOCK_50);
    all_zero("rst");
    check("wclk", fb_wclk, CLOCK_50);
    tick();
    c0_valid = 1'b0;
    rst_n    = 1'b1;

    // Single client write.
    tick();
    c0_valid = 1'b1; c0_adr = 16'h0010; c0_d = 24'hFF0000;
    @(negedge CLOCK_50);
    check("single_rdy0", c0_ready, 1);
    check("single_rdy1", c1_ready, 0);
    push(16'h0010, 24'hFF0000);
    tick();
    c0_valid = 1'b0;
    drain();

    // Contention after reset: c0,c1,c0,c1.
    do_reset();
    a0 = 16'h0100;
    a1 = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      c0_valid = 1'b1; c0_adr = a0; c0_d = {8'hC0, a0};
      c1_valid = 1'b1; c1_adr = a1; c1_d = {8'hC1, a1};
      @(negedge CLOCK_50);
      g = i % 2;
      check("rr_rdy0", c0_ready, (g == 0) ? 1 : 0);
      check("rr_rdy1", c1_ready, (g == 1) ? 1 : 0);
      if (g == 0) begin push(a0, {8'hC0, a0}); a0++; end
      else        begin push(a1, {8'hC1, a1}); a1++; end
    end
    tick();
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    drain();

    // Fill 100..103 with c0 held; a second start mid-fill must be ignored.
    tick();
    fill_start = 1'b1; fill_first = 16'd100; fill_last = 16'd103; fill_color = 24'h00FF00;
    c0_valid = 1'b1; c0_adr = 16'h0300; c0_d = 24'h777777;
    @(negedge CLOCK_50);
    check("fs_rdy0", c0_ready, 0);
    for (int k = 0; k < 4; k++) push(AW'(100 + k), 24'h00FF00);
    for (int k = 1; k <= 4; k++) begin
      tick();
      fill_start = (k == 2);
      if (k == 2) begin
        fill_first = 16'd500; fill_last = 16'd510; fill_color = 24'h0000FF;
      end
      @(negedge CLOCK_50);
      check("fill_busy", fill_busy, 1);
      check("fill_rdy0", c0_ready, 0);
      check("fill_nodone", fill_done, 0);
    end
    tick();
    @(negedge CLOCK_50);
    check("fill_done", fill_done, 1);
    check("fill_busy_off", fill_busy, 0);
    check("done_we", fb_we, 1);
    check("done_adr", fb_wadr, 103);
    check("post_rdy0", c0_ready, 1);
    push(16'h0300, 24'h777777);
    tick();
    c0_valid = 1'b0;
    @(negedge CLOCK_50);
    check("done_once", fill_done, 0);
    check("no_refill", fill_busy, 0);
    drain();

    // Clamp: 63998..0xFFFF writes only 63998 and 63999.
    tick();
    fill_start = 1'b1; fill_first = 16'd63998; fill_last = 16'hFFFF; fill_color = 24'h123456;
    push(16'd63998, 24'h123456);
    push(16'd63999, 24'h123456);
    tick();
    fill_start = 1'b0;
    @(negedge CLOCK_50);
    check("clamp_busy1", fill_busy, 1);
    tick();
    @(negedge CLOCK_50);
    check("clamp_busy2", fill_busy, 1);
    check("clamp_nodone", fill_done, 0);
    tick();
    @(negedge CLOCK_50);
    check("clamp_done", fill_done, 1);
    check("clamp_busy_off", fill_busy, 0);
    drain();

    // Out-of-range c1 write, then the last valid address.
    tick();
    c1_valid = 1'b1; c1_adr = 16'd64000; c1_d = 24'hDEAD00;
    @(negedge CLOCK_50);
    check("oob_rdy1", c1_ready, 1);
    tick();
    c1_adr = 16'd63999; c1_d = 24'hBEEF01;
    @(negedge CLOCK_50);
    check("oob_pulse", oob, 1);
    check("oob_we", fb_we, 0);
    check("edge_rdy1", c1_ready, 1);
    push(16'd63999, 24'hBEEF01);
    tick();
    c1_valid = 1'b0;
    @(negedge CLOCK_50);
    check("oob_clear", oob, 0);
    drain();

    // Empty fill.
    tick();
    fill_start = 1'b1; fill_first = 16'd5; fill_last = 16'd4;
    @(negedge CLOCK_50);
    check("empty_busy0", fill_busy, 0);
    tick();
    fill_start = 1'b0;
    @(negedge CLOCK_50);
    check("empty_done", fill_done, 1);
    check("empty_busy", fill_busy, 0);
    tick();
    @(negedge CLOCK_50);
    check("empty_done_off", fill_done, 0);

    // Single-word fill (first == last).
    tick();
    fill_start = 1'b1; fill_first = 16'd7; fill_last = 16'd7; fill_color = 24'h0A0B0C;
    push(16'd7, 24'h0A0B0C);
    tick();
    fill_start = 1'b0;
    @(negedge CLOCK_50);
    check("one_busy", fill_busy, 1);
    check("one_nodone", fill_done, 0);
    tick();
    @(negedge CLOCK_50);
    check("one_done", fill_done, 1);
    check("one_busy_off", fill_busy, 0);
    drain();

    // Reset in the middle of a 0..999 fill, after writes 0..9.
    tick();
    fill_start = 1'b1; fill_first = 16'd0; fill_last = 16'd999; fill_color = 24'hABCDEF;
    for (int k = 0; k < 10; k++) push(AW'(k), 24'hABCDEF);
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    tick();
    rst_n = 1'b0;
    @(negedge CLOCK_50);
    all_zero("midrst");
    check("midrst_q", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      check("midrst_nodone", fill_done, 0);
      check("midrst_idle", fill_busy, 0);
    end
    tick();
    c0_valid = 1'b1; c0_adr = 16'h0042; c0_d = 24'h424242;
    @(negedge CLOCK_50);
    check("after_rst_rdy0", c0_ready, 1);
    push(16'h0042, 24'h424242);
    tick();
    c0_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
